fir_axis_out: RTL and testbench

FIR_AXIS_OUT -- requirements
Module: fir_axis_out

---
 rtl/fir_axis_out.sv | 124 ++++++++++++
 tb/tb_fir_axis_out.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_axis_out.sv
// Requantises 32-bit FIR accumulator samples to 16 bits and streams them out of a show-ahead FIFO as framed AXI4-Stream.
// Optional FIR_AXIS_OUT_ROUND_EN selects round-half-up instead of truncation in the quantiser.
module fir_axis_out #(
    parameter int SHIFT     = 15,
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    input  logic        clr_overflow,
    output logic        overflow,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FRM_W = $clog2(FRAME_LEN);

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [FRM_W-1:0] frame_cnt_reg, frame_cnt_next;
    logic             overflow_reg, overflow_next;
    logic [15:0]      mem [DEPTH];

    logic signed [32:0] q_ext;
    logic signed [32:0] q_biased;
    logic signed [32:0] q_shifted;
    logic [15:0]        q_data;
    logic               push;
    logic               pop;
    logic               drop;

    // Sign-extend to 33 bits so the rounding bias can never wrap.
    assign q_ext = {s_data[31], s_data};
`ifdef FIR_AXIS_OUT_ROUND_EN
    localparam logic signed [32:0] ROUND_K = 33'sd1 <<< (SHIFT - 1);
    assign q_biased = q_ext + ROUND_K;
`else
    assign q_biased = q_ext;
`endif
    assign q_shifted = q_biased >>> SHIFT;

    always_comb begin
        q_data = q_shifted[15:0];
        if (q_shifted > 33'sd32767) begin
            q_data = 16'h7FFF;
        end else if (q_shifted < -33'sd32768) begin
            q_data = 16'h8000;
        end
    end

    assign s_ready       = (count_reg != CNT_W'(DEPTH));
    assign m_axis_tvalid = (count_reg != '0);
    assign m_axis_tdata  = mem[rd_ptr_reg];
    assign m_axis_tlast  = (frame_cnt_reg == FRM_W'(FRAME_LEN - 1)) && m_axis_tvalid;
    assign overflow      = overflow_reg;

    assign push = s_valid && s_ready;
    assign drop = s_valid && !s_ready;
    assign pop  = m_axis_tvalid && m_axis_tready;

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        frame_cnt_next = frame_cnt_reg;
        overflow_next  = overflow_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            if (frame_cnt_reg == FRM_W'(FRAME_LEN - 1)) begin
                frame_cnt_next = '0;
            end else begin
                frame_cnt_next = frame_cnt_reg + FRM_W'(1);
            end
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            overflow_next = 1'b1;
        end else if (clr_overflow) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            frame_cnt_reg <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            frame_cnt_reg <= frame_cnt_next;
            overflow_reg  <= overflow_next;
        end
    end

    // Storage is cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr_reg] <= q_data;
        end
    end
endmodule

// File: tb/tb_fir_axis_out.sv
// Scoreboard bench for fir_axis_out: stimulus queues expected beats, a negedge monitor pops and compares on each handshake.
module tb_fir_axis_out;
    localparam int SHIFT = 15;
    localparam int DEPTH = 8;
    localparam int FRAME = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        clr_overflow;
    logic        overflow;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_beat = 0;
    logic [16:0] exp_q [$];

    fir_axis_out #(.SHIFT(SHIFT), .DEPTH(DEPTH), .FRAME_LEN(FRAME)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .clr_overflow(clr_overflow), .overflow(overflow), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_beat(input logic [15:0] d);
        exp_q.push_back({(exp_beat % FRAME) == FRAME - 1, d});
        exp_beat++;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic rdy, input logic clr);
        s_valid = v; s_data = d; m_axis_tready = rdy; clr_overflow = clr;
        @(posedge clk); #1;
        s_valid = 1'b0; clr_overflow = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; s_valid = 1'b0; clr_overflow = 1'b0;
        #1;
        exp_q.delete();
        exp_beat = 0;
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
        chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic drain(input logic toggle);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && cyc < 64) begin
            drive(1'b0, 32'd0, toggle ? logic'(cyc % 2 == 0) : 1'b1, 1'b0);
            cyc++;
        end
        chk("drain_done", 32'(cyc < 64), 32'd1);
        chk("drain_tvalid", 32'(m_axis_tvalid), 32'd0);
    endtask

    // Monitor: compare every handshake against the queue and hold-stability through stalls.
    logic        stall_pend = 1'b0;
    logic [15:0] held_data;
    logic        held_last;
    always @(negedge clk) begin
        if (reset) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend && m_axis_tvalid) begin
                chk("tdata_stable", 32'(m_axis_tdata), 32'(held_data));
                chk("tlast_stable", 32'(m_axis_tlast), 32'(held_last));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(m_axis_tdata), 32'hDEAD_BEEF);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    chk("beat_tdata", 32'(m_axis_tdata), 32'(e[15:0]));
                    chk("beat_tlast", 32'(m_axis_tlast), 32'(e[16]));
                    $display("beat data=0x%04h last=%0b", m_axis_tdata, m_axis_tlast);
                end
                stall_pend = 1'b0;
            end else if (m_axis_tvalid) begin
                stall_pend = 1'b1;
                held_data  = m_axis_tdata;
                held_last  = m_axis_tlast;
            end else begin
                stall_pend = 1'b0;
            end
        end
    end

    typedef struct {
        logic [31:0] din;
        logic [15:0] trunc;
        logic [15:0] rnd;
    } qvec_t;

    qvec_t qv [11] = '{
        '{32'h0000_4000, 16'h0000, 16'h0001},
        '{32'hFFFF_C000, 16'hFFFF, 16'h0000},
        '{32'h7FFF_FFFF, 16'h7FFF, 16'h7FFF},
        '{32'h8000_0000, 16'h8000, 16'h8000},
        '{32'h0001_8000, 16'h0003, 16'h0003},
        '{32'hFFFE_8000, 16'hFFFD, 16'hFFFD},
        '{32'h4000_0000, 16'h7FFF, 16'h7FFF},
        '{32'h0000_7FFF, 16'h0000, 16'h0001},
        '{32'hFFFF_BFFF, 16'hFFFF, 16'hFFFF},
        '{32'h3FFF_C000, 16'h7FFF, 16'h7FFF},
        '{32'hC000_0000, 16'h8000, 16'h8000}
    };

    initial begin
        reset = 1'b1; s_valid = 1'b0; s_data = '0; clr_overflow = 1'b0; m_axis_tready = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // Quantiser vectors, sink always ready.
        for (int i = 0; i < 11; i++) begin
`ifdef FIR_AXIS_OUT_ROUND_EN
            expect_beat(qv[i].rnd);
`else
            expect_beat(qv[i].trunc);
`endif
            drive(1'b1, qv[i].din, 1'b1, 1'b0);
        end
        drain(1'b0);

        // Backpressure: fill, drop, clear interactions.
        do_reset();
        for (int v = 1; v <= DEPTH; v++) begin
            chk("s_ready_before_push", 32'(s_ready), 32'd1);
            expect_beat(16'(v));
            drive(1'b1, 32'(v) << SHIFT, 1'b0, 1'b0);
        end
        chk("s_ready_full", 32'(s_ready), 32'd0);
        chk("overflow_before_drop", 32'(overflow), 32'd0);
        drive(1'b1, 32'd9 << SHIFT, 1'b0, 1'b0);
        chk("overflow_after_drop", 32'(overflow), 32'd1);
        drive(1'b1, 32'd10 << SHIFT, 1'b0, 1'b1);
        chk("overflow_drop_beats_clr", 32'(overflow), 32'd1);
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        chk("overflow_cleared", 32'(overflow), 32'd0);
        drive(1'b1, 32'd11 << SHIFT, 1'b1, 1'b0);
        chk("overflow_drop_with_pop", 32'(overflow), 32'd1);
        chk("s_ready_after_pop", 32'(s_ready), 32'd1);
        drain(1'b0);
        drive(1'b0, 32'd0, 1'b1, 1'b1);
        chk("overflow_final_clr", 32'(overflow), 32'd0);

        // Framing with ready toggling each cycle.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            expect_beat(16'(10 + c));
            drive(1'b1, 32'(10 + c) << SHIFT, logic'(c % 2 == 0), 1'b0);
        end
        drain(1'b1);

        // Reset mid-frame with samples buffered.
        do_reset();
        expect_beat(16'd20);
        drive(1'b1, 32'd20 << SHIFT, 1'b1, 1'b0);
        expect_beat(16'd21);
        drive(1'b1, 32'd21 << SHIFT, 1'b1, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 32'(22 + c) << SHIFT, 1'b0, 1'b0);
        end
        chk("tvalid_before_reset", 32'(m_axis_tvalid), 32'd1);
        chk("queue_before_reset", 32'(exp_q.size()), 32'd0);
        do_reset();
        for (int c = 0; c < 4; c++) begin
            expect_beat(16'(30 + c));
            drive(1'b1, 32'(30 + c) << SHIFT, 1'b1, 1'b0);
        end
        drain(1'b0);

        chk("queue_empty_end", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
